// File: rtl/sensor_conditioner.sv
// rtl/sensor_conditioner.sv - contact debouncer and moving-average temperature smoother
// Four synchronised, debounced contacts plus an N-sample running average of temperature.
module sensor_conditioner #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AVG_LOG2        = 2,
  parameter int TEMP_INIT       = 60
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic       raw_fd,
  input  logic       raw_rd,
  input  logic       raw_win,
  input  logic       raw_fire,
  input  logic [7:0] raw_temp,
  input  logic       temp_valid,
  output logic       SFD,
  output logic       SRD,
  output logic       SW,
  output logic       SFA,
  output logic [7:0] ST,
  output logic       sens_evt
);

  localparam int CW  = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int N   = 1 << AVG_LOG2;
  localparam int SUW = 8 + AVG_LOG2;
  localparam int WPW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CW-1:0]  CNT_MAX  = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [7:0]     INIT8    = 8'(TEMP_INIT);
  localparam logic [SUW-1:0] SUM_INIT = SUW'(TEMP_INIT) << AVG_LOG2;

  logic [3:0]    w_raw;
  logic [3:0]    w_flip;
  logic [3:0]    r_s1;
  logic [3:0]    r_s2;
  logic [3:0]    r_out;
  logic [CW-1:0] r_cnt [4];
  logic          r_evt;

  logic [7:0]     r_slot [N];
  logic [SUW-1:0] r_sum;
  logic [WPW-1:0] r_wp;
  logic [7:0]     r_st;
  logic [7:0]     w_avg;

  assign w_raw = {raw_fire, raw_win, raw_rd, raw_fd};

  // A channel flips only after its synced value has disagreed for DEBOUNCE_CYCLES edges.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 4; i++) begin
      w_flip[i] = (r_s2[i] != r_out[i]) && (r_cnt[i] == CNT_MAX);
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_s1  <= '0;
      r_s2  <= '0;
      r_out <= '0;
      r_evt <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_s1  <= w_raw;
      r_s2  <= r_s1;
      r_evt <= |w_flip;
      for (int i = 0; i < 4; i++) begin
        if (r_s2[i] == r_out[i]) begin
          r_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_out[i] <= r_s2[i];
          r_cnt[i] <= '0;
        end else begin
          r_cnt[i] <= r_cnt[i] + CW'(1);
        end
      end
    end
  end

  assign w_avg = 8'(r_sum >> AVG_LOG2);

  // Running sum swaps the oldest slot for the new sample; ST follows one edge later.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      for (int i = 0; i < N; i++) begin
        r_slot[i] <= INIT8;
      end
      r_sum <= SUM_INIT;
      r_wp  <= '0;
      r_st  <= INIT8;
    end else begin
      if (temp_valid) begin
        r_slot[r_wp] <= raw_temp;
        r_sum        <= r_sum - SUW'(r_slot[r_wp]) + SUW'(raw_temp);
        r_wp         <= (AVG_LOG2 == 0) ? '0 : r_wp + WPW'(1);
      end
      r_st <= w_avg;
    end
  end

  assign SFD      = r_out[0];
  assign SRD      = r_out[1];
  assign SW       = r_out[2];
  assign SFA      = r_out[3];
  assign ST       = r_st;
  assign sens_evt = r_evt;

endmodule

// File: tb/tb_sensor_conditioner.sv
// tb/tb_sensor_conditioner.sv - self-checking bench for sensor_conditioner
// Contacts are checked edge by edge; temperature results go through a scoreboard queue.
module tb_sensor_conditioner;

  logic       clk = 1'b0;
  logic       Rst;
  logic       raw_fd, raw_rd, raw_win, raw_fire;
  logic [7:0] raw_temp;
  logic       temp_valid;
  logic       SFD, SRD, SW, SFA;
  logic [7:0] ST;
  logic       sens_evt;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q [$];
  logic [7:0] m_slot [4];
  int         m_wp;
  int         m_sum;

  sensor_conditioner #(.DEBOUNCE_CYCLES(4), .AVG_LOG2(2), .TEMP_INIT(60)) dut (
    .clk(clk), .Rst(Rst),
    .raw_fd(raw_fd), .raw_rd(raw_rd), .raw_win(raw_win), .raw_fire(raw_fire),
    .raw_temp(raw_temp), .temp_valid(temp_valid),
    .SFD(SFD), .SRD(SRD), .SW(SW), .SFA(SFA), .ST(ST), .sens_evt(sens_evt)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    for (int i = 0; i < 4; i++) m_slot[i] = 8'd60;
    m_wp  = 0;
    m_sum = 240;
  endtask

  // Drives one sample for one edge and queues the average that should appear one edge later.
  task automatic drive_sample(input logic [7:0] v);
    raw_temp   = v;
    temp_valid = 1'b1;
    m_sum      = m_sum - int'(m_slot[m_wp]) + int'(v);
    m_slot[m_wp] = v;
    m_wp       = (m_wp + 1) % 4;
    exp_q.push_back(8'(m_sum / 4));
    tick();
    temp_valid = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] exp;
    Rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      {raw_fd, raw_rd, raw_win, raw_fire} = 4'($urandom);
      raw_temp   = 8'($urandom);
      temp_valid = 1'($urandom);
      tick();
      checks++;
      if ({SFD, SRD, SW, SFA, sens_evt} !== 5'b0 || ST !== 8'd60) begin
        errors++;
        $display("FAIL reset_hold: contacts/evt=%b ST=%0d, required 00000 ST=60",
                 {SFD, SRD, SW, SFA, sens_evt}, ST);
      end
    end
    {raw_fd, raw_rd, raw_win, raw_fire} = 4'b0;
    temp_valid = 1'b0;
    Rst = 1'b0;
    model_reset();
    exp = 8'd60;
    for (int k = 0; k < 6; k++) begin
      tick();
      checks++;
      if ({SFD, SRD, SW, SFA, sens_evt} !== 5'b0 || ST !== exp) begin
        errors++;
        $display("FAIL reset_release: contacts/evt=%b ST=%0d, required 00000 ST=%0d",
                 {SFD, SRD, SW, SFA, sens_evt}, ST, exp);
      end
    end
  endtask

  task automatic test_contact_flip;
    raw_fd = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (SFD !== (e >= 6) || sens_evt !== (e == 6)) begin
        errors++;
        $display("FAIL fd_rise edge %0d: SFD=%b evt=%b, required SFD=%b evt=%b",
                 e, SFD, sens_evt, (e >= 6), (e == 6));
      end
    end
    raw_fd = 1'b0;
    for (int e = 1; e <= 8; e++) begin
      tick();
      checks++;
      if (SFD !== (e < 6) || sens_evt !== (e == 6)) begin
        errors++;
        $display("FAIL fd_fall edge %0d: SFD=%b evt=%b, required SFD=%b evt=%b",
                 e, SFD, sens_evt, (e < 6), (e == 6));
      end
    end
  endtask

  task automatic test_bounce;
    raw_fire = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (e == 3) raw_fire = 1'b0;
      checks++;
      if (SFA !== 1'b0 || sens_evt !== 1'b0) begin
        errors++;
        $display("FAIL fire_glitch3 edge %0d: SFA=%b evt=%b, required 0 0", e, SFA, sens_evt);
      end
    end
    raw_fire = 1'b1;
    for (int e = 1; e <= 14; e++) begin
      tick();
      if (e == 4) raw_fire = 1'b0;
      checks++;
      if (SFA !== (e >= 6 && e < 10) || sens_evt !== (e == 6 || e == 10)) begin
        errors++;
        $display("FAIL fire_pulse4 edge %0d: SFA=%b evt=%b, required SFA=%b evt=%b",
                 e, SFA, sens_evt, (e >= 6 && e < 10), (e == 6 || e == 10));
      end
    end
  endtask

  task automatic test_simultaneous;
    int n_evt;
    n_evt   = 0;
    raw_rd  = 1'b1;
    raw_win = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      if (sens_evt === 1'b1) n_evt++;
      checks++;
      if (SRD !== (e >= 6) || SW !== (e >= 6)) begin
        errors++;
        $display("FAIL rd_win_same_edge edge %0d: SRD=%b SW=%b, required both %b",
                 e, SRD, SW, (e >= 6));
      end
    end
    checks++;
    if (n_evt != 1) begin
      errors++;
      $display("FAIL rd_win_single_evt: %0d pulses, required 1", n_evt);
    end
    raw_rd  = 1'b0;
    raw_win = 1'b0;
    repeat (8) tick();
  endtask

  task automatic test_average;
    logic [7:0] exp;
    logic [7:0] const_exp [8];
    const_exp = '{8'd65, 8'd70, 8'd75, 8'd80, 8'd70, 8'd60, 8'd50, 8'd40};
    for (int i = 0; i < 8; i++) begin
      drive_sample((i < 4) ? 8'd80 : 8'd40);
      if (i > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (ST !== exp || ST !== const_exp[i-1]) begin
          errors++;
          $display("FAIL avg_step %0d: ST=%0d, required %0d", i - 1, ST, const_exp[i-1]);
        end
      end
    end
    tick();
    exp = exp_q.pop_front();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (ST !== exp || ST !== const_exp[7]) begin
        errors++;
        $display("FAIL avg_hold %0d: ST=%0d, required %0d", k, ST, const_exp[7]);
      end
      tick();
    end
  endtask

  task automatic test_extremes;
    logic [7:0] exp;
    for (int i = 0; i < 4; i++) begin
      drive_sample(8'd255);
      if (i > 0) begin
        exp = exp_q.pop_front();
        checks++;
        if (ST !== exp) begin
          errors++;
          $display("FAIL max_ramp %0d: ST=%0d, required %0d", i - 1, ST, exp);
        end
      end
    end
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (ST !== 8'd255 || exp !== 8'd255) begin
      errors++;
      $display("FAIL max_full: ST=%0d, required 255", ST);
    end
    drive_sample(8'd255);
    drive_sample(8'd255);
    exp = exp_q.pop_front();
    checks++;
    if (ST !== exp) begin
      errors++;
      $display("FAIL max_before_reset: ST=%0d, required %0d", ST, exp);
    end
    Rst = 1'b1;
    #1;
    checks++;
    if (ST !== 8'd60 || {SFD, SRD, SW, SFA, sens_evt} !== 5'b0) begin
      errors++;
      $display("FAIL mid_reset: ST=%0d contacts/evt=%b, required ST=60 00000",
               ST, {SFD, SRD, SW, SFA, sens_evt});
    end
    exp_q.delete();
    model_reset();
    #2;
    Rst = 1'b0;
    drive_sample(8'd100);
    tick();
    exp = exp_q.pop_front();
    checks++;
    if (ST !== exp || ST !== 8'd70) begin
      errors++;
      $display("FAIL after_reset_sample: ST=%0d, required 70", ST);
    end
  endtask

  initial begin
    Rst        = 1'b1;
    raw_fd     = 1'b0;
    raw_rd     = 1'b0;
    raw_win    = 1'b0;
    raw_fire   = 1'b0;
    raw_temp   = 8'd0;
    temp_valid = 1'b0;
    model_reset();
    #1;
    test_reset();
    test_contact_flip();
    test_bounce();
    test_simultaneous();
    test_average();
    test_extremes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
